// File: rtl/apb_reg_responder.sv
// APB-style register responder: a bank of 21-bit general registers, a
// read-only transfer counter, a control register that can request a CPU
// reset, and a programmable number of wait states before PREADY.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | no transfer; setup phase (PSEL=1, PENABLE=0) is captured here
// S_ACCESS | transfer captured; counting wait states, PREADY at count zero
module apb_reg_responder #(
   parameter int NUM_REGS    = 8,
   parameter int WAIT_CYCLES = 2,
   parameter int CNT_W       = 4
) (
   input  logic        CCLK,
   input  logic        CPURESET,
   input  logic        PERIPHCLR,
   input  logic        PSEL,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [7:0]  PADDR,
   input  logic [20:0] PWDATA,
   output logic [20:0] PRDATA,
   output logic        PREADY,
   output logic        PSLVERR,
   output logic        INCPURESET
);

   localparam logic [CNT_W-1:0] LP_WAIT  = CNT_W'(WAIT_CYCLES);
   localparam logic [7:0]       LP_CNT_A = 8'hFE;
   localparam logic [7:0]       LP_CTL_A = 8'hFF;

   typedef enum logic {S_IDLE, S_ACCESS} state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [7:0]       r_addr;
   logic             r_write;
   logic [20:0]      r_wdata;
   logic             r_err;
   logic [20:0]      r_rdata;
   logic             r_incpu;
   logic [20:0]      r_regs [NUM_REGS];
   logic [20:0]      r_xfer_cnt;

   logic             w_done;
   logic             w_paddr_reg;
   logic             w_paddr_err;
   logic [20:0]      w_sel_rdata;

   // Completion is decoded from registered state plus the bus handshake only.
   assign w_done     = (r_state == S_ACCESS) && (r_cnt == '0) && PSEL && PENABLE;
   assign PREADY     = w_done;
   assign PSLVERR    = w_done && r_err;
   assign PRDATA     = r_rdata;
   assign INCPURESET = r_incpu;

   // Decode the setup-phase address: read data source and error classification.
   always_comb begin
      w_paddr_reg = 1'b0;
      w_sel_rdata = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (PADDR == 8'(i)) begin
            w_paddr_reg = 1'b1;
            w_sel_rdata = r_regs[i];
         end
      end
      if (PADDR == LP_CNT_A && !PWRITE) begin
         w_sel_rdata = r_xfer_cnt;
      end
      // Writes to the count location are errors; the control location never errors.
      w_paddr_err = !w_paddr_reg && (PADDR != LP_CTL_A) &&
                    !(PADDR == LP_CNT_A && !PWRITE);
   end

   // Transfer sequencing: capture, wait-state countdown, completion and abort.
   always_ff @(posedge CCLK or posedge CPURESET) begin
      if (CPURESET) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_write <= 1'b0;
         r_wdata <= '0;
         r_err   <= 1'b0;
         r_rdata <= '0;
         r_incpu <= 1'b0;
      end else begin
         r_incpu <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (PSEL && !PENABLE) begin
                  r_addr  <= PADDR;
                  r_write <= PWRITE;
                  r_wdata <= PWDATA;
                  r_err   <= w_paddr_err;
                  r_rdata <= w_paddr_err ? 21'd0 : w_sel_rdata;
                  r_cnt   <= LP_WAIT;
                  r_state <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               if (!PSEL) begin
                  r_state <= S_IDLE;
               end else if (PENABLE) begin
                  if (r_cnt == '0) begin
                     r_state <= S_IDLE;
                     r_incpu <= r_write && (r_addr == LP_CTL_A) && r_wdata[0];
                  end else begin
                     r_cnt <= r_cnt - 1'b1;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Register bank and transfer count; a peripheral clear beats a same-edge commit.
   always_ff @(posedge CCLK or posedge CPURESET) begin
      if (CPURESET) begin
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
         r_xfer_cnt <= '0;
      end else if (PERIPHCLR) begin
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
         r_xfer_cnt <= '0;
      end else if (w_done) begin
         r_xfer_cnt <= r_xfer_cnt + 21'd1;
         for (int i = 0; i < NUM_REGS; i++) begin
            if (r_write && !r_err && (r_addr == 8'(i))) r_regs[i] <= r_wdata;
         end
      end
   end

endmodule

// File: tb/tb_apb_reg_responder.sv
// Scoreboard bench for apb_reg_responder: one instance with two wait states
// and one with none, sharing all bus signals except PSEL.
module tb_apb_reg_responder;

   logic        CCLK;
   logic        CPURESET;
   logic        PERIPHCLR;
   logic        psel_a, psel_b;
   logic        PENABLE;
   logic        PWRITE;
   logic [7:0]  PADDR;
   logic [20:0] PWDATA;
   logic [20:0] prdata_a, prdata_b;
   logic        pready_a, pready_b;
   logic        pslverr_a, pslverr_b;
   logic        incpu_a, incpu_b;

   typedef struct {
      logic [20:0] rdata;
      logic        err;
      logic        chk_rd;
      int          lat;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   acc_a = 0, acc_b = 0;
   int   pulses_a = 0, pulses_b = 0;

   apb_reg_responder #(.NUM_REGS(8), .WAIT_CYCLES(2), .CNT_W(4)) u_dut_a (
      .CCLK(CCLK), .CPURESET(CPURESET), .PERIPHCLR(PERIPHCLR), .PSEL(psel_a),
      .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
      .PRDATA(prdata_a), .PREADY(pready_a), .PSLVERR(pslverr_a), .INCPURESET(incpu_a));

   apb_reg_responder #(.NUM_REGS(8), .WAIT_CYCLES(0), .CNT_W(4)) u_dut_b (
      .CCLK(CCLK), .CPURESET(CPURESET), .PERIPHCLR(PERIPHCLR), .PSEL(psel_b),
      .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
      .PRDATA(prdata_b), .PREADY(pready_b), .PSLVERR(pslverr_b), .INCPURESET(incpu_b));

   initial CCLK = 1'b0;
   always #5 CCLK = ~CCLK;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Monitor: pops the expected response whenever a DUT raises PREADY.
   always @(negedge CCLK) begin
      exp_t e;
      if (incpu_a) pulses_a++;
      if (incpu_b) pulses_b++;
      if (psel_a && PENABLE) begin
         acc_a++;
         if (pready_a) begin
            if (qa.size() == 0) chk("a_unexpected_pready", 1, 0);
            else begin
               e = qa.pop_front();
               chk("a_latency", acc_a, e.lat);
               chk("a_pslverr", {31'd0, pslverr_a}, {31'd0, e.err});
               if (e.chk_rd) chk("a_prdata", {11'd0, prdata_a}, {11'd0, e.rdata});
            end
            acc_a = 0;
         end
      end else acc_a = 0;
      if (psel_b && PENABLE) begin
         acc_b++;
         if (pready_b) begin
            if (qb.size() == 0) chk("b_unexpected_pready", 1, 0);
            else begin
               e = qb.pop_front();
               chk("b_latency", acc_b, e.lat);
               chk("b_pslverr", {31'd0, pslverr_b}, {31'd0, e.err});
               if (e.chk_rd) chk("b_prdata", {11'd0, prdata_b}, {11'd0, e.rdata});
            end
            acc_b = 0;
         end
      end else acc_b = 0;
   end

   // Full transfer on DUT d (0 = two wait states, 1 = none); returns just after the completion edge.
   task automatic xfer(input int d, input logic w, input logic [7:0] a, input logic [20:0] wd,
                       input logic [20:0] er, input logic ee);
      exp_t e;
      bit   got;
      e.rdata = er; e.err = ee; e.chk_rd = !w; e.lat = (d == 0) ? 3 : 1;
      if (d == 0) qa.push_back(e); else qb.push_back(e);
      psel_a = (d == 0); psel_b = (d == 1);
      PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = wd;
      @(posedge CCLK); #1;
      PENABLE = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge CCLK);
         if ((d == 0) ? pready_a : pready_b) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) chk("pready_timeout", 0, 1);
      @(posedge CCLK); #1;
      psel_a = 1'b0; psel_b = 1'b0; PENABLE = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      CPURESET = 1'b1; PERIPHCLR = 1'b0;
      psel_a = 1'b0; psel_b = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      PADDR = '0; PWDATA = '0;
      repeat (2) @(negedge CCLK);
      chk("rst_prdata", {11'd0, prdata_a}, 0);
      chk("rst_pready", {31'd0, pready_a}, 0);
      chk("rst_pslverr", {31'd0, pslverr_a}, 0);
      chk("rst_incpu", {31'd0, incpu_a}, 0);
      @(posedge CCLK); #1;
      CPURESET = 1'b0;
      @(posedge CCLK); #1;

      xfer(0, 0, 8'h03, 0, 21'h0, 0);            // count 1
      xfer(0, 1, 8'h05, 21'h1ABCDE, 0, 0);       // 2
      xfer(0, 0, 8'h05, 0, 21'h1ABCDE, 0);       // 3
      xfer(0, 0, 8'hFE, 0, 21'd3, 0);            // 4
      xfer(0, 1, 8'h40, 21'h123, 0, 1);          // 5
      xfer(0, 1, 8'hFE, 21'h1FFFFF, 0, 1);       // 6
      xfer(0, 0, 8'hFE, 0, 21'd6, 0);            // 7

      xfer(0, 1, 8'hFF, 21'h000001, 0, 0);       // 8
      @(negedge CCLK); chk("incpu_pulse", {31'd0, incpu_a}, 1);
      @(negedge CCLK); chk("incpu_one_cycle", {31'd0, incpu_a}, 0);
      @(posedge CCLK); #1;
      xfer(0, 1, 8'hFF, 21'h000000, 0, 0);       // 9
      @(negedge CCLK); chk("incpu_no_pulse", {31'd0, incpu_a}, 0);
      @(posedge CCLK); #1;
      xfer(0, 0, 8'hFF, 0, 21'h0, 0);            // 10
      xfer(0, 0, 8'h09, 0, 21'h0, 1);            // 11

      // Abort a write to 0x05 during a wait state.
      psel_a = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h05; PWDATA = 21'h000777;
      @(posedge CCLK); #1; PENABLE = 1'b1;
      @(posedge CCLK); #1; psel_a = 1'b0; PENABLE = 1'b0;
      @(posedge CCLK); #1;
      xfer(0, 0, 8'h05, 0, 21'h1ABCDE, 0);       // 12
      xfer(0, 0, 8'hFE, 0, 21'd12, 0);           // 13

      xfer(0, 1, 8'h07, 21'h00FACE, 0, 0);       // 14
      xfer(0, 0, 8'h07, 0, 21'h00FACE, 0);       // 15
      xfer(0, 0, 8'h08, 0, 21'h0, 1);            // 16

      // Peripheral clear held across a write: transfer completes, write lost, bank and count cleared.
      PERIPHCLR = 1'b1;
      xfer(0, 1, 8'h02, 21'h000055, 0, 0);
      PERIPHCLR = 1'b0;
      xfer(0, 0, 8'h02, 0, 21'h0, 0);            // 1
      xfer(0, 0, 8'h05, 0, 21'h0, 0);            // 2
      xfer(0, 0, 8'hFE, 0, 21'd2, 0);            // 3

      // Zero wait states, back-to-back with no idle cycle between transfers.
      xfer(1, 1, 8'h00, 21'h000011, 0, 0);
      xfer(1, 1, 8'h01, 21'h1FFFFF, 0, 0);
      xfer(1, 0, 8'h00, 0, 21'h000011, 0);
      xfer(1, 0, 8'h01, 0, 21'h1FFFFF, 0);
      xfer(1, 0, 8'hFE, 0, 21'd4, 0);

      // Reset in the cycle where PREADY is already asserted.
      xfer(0, 1, 8'h04, 21'h013579, 0, 0);
      psel_a = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h03; PWDATA = 21'h0AAAAA;
      @(posedge CCLK); #1; PENABLE = 1'b1;
      @(posedge CCLK); #1;
      @(posedge CCLK); #1;
      chk("pready_before_reset", {31'd0, pready_a}, 1);
      CPURESET = 1'b1;
      #1;
      chk("pready_during_reset", {31'd0, pready_a}, 0);
      psel_a = 1'b0; PENABLE = 1'b0;
      @(posedge CCLK); #1;
      CPURESET = 1'b0;
      @(posedge CCLK); #1;
      xfer(0, 0, 8'h04, 0, 21'h0, 0);            // 1
      xfer(0, 0, 8'h03, 0, 21'h0, 0);            // 2
      xfer(0, 0, 8'hFE, 0, 21'd2, 0);            // 3

      repeat (3) @(posedge CCLK);
      chk("a_queue_drained", qa.size(), 0);
      chk("b_queue_drained", qb.size(), 0);
      chk("a_incpu_pulses", pulses_a, 1);
      chk("b_incpu_pulses", pulses_b, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
